// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round helper functions and the engine state encoding.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, COMPRESS, ADD, WRITE, DONE} state_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; next working vars packed a..h, a in the MSBs.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  input  logic [31:0]  c,
  input  logic [31:0]  d,
  input  logic [31:0]  e,
  input  logic [31:0]  f,
  input  logic [31:0]  g,
  input  logic [31:0]  h,
  input  logic [31:0]  w,
  input  logic [31:0]  k,
  output logic [255:0] nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1  = h + ep1(e) + ch(e, f, g) + k + w;
  assign t2  = ep0(a) + maj(a, b, c);
  assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_engine.sv
// Multi-block SHA-256 over a word-aligned message in shared memory; digest written back to memory.
module sha256_stream_engine
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [11:0]       num_words,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] hash_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              memory_clk,
  output logic              enable_write,
  output logic [ADDR_W-1:0] memory_addr,
  output logic [31:0]       memory_write_data,
  input  logic [31:0]       memory_read_data
);

  localparam logic [12:0] MAX_LEN = 13'(MAX_WORDS);

  state_t            state;
  state_t            state_next;
  logic [6:0]        cnt;
  logic [8:0]        blk;
  logic [8:0]        nb;
  logic [11:0]       nw;
  logic [ADDR_W-1:0] in_base;
  logic [ADDR_W-1:0] out_base;
  logic              err_q;
  logic [31:0]       hv  [0:7];
  logic [31:0]       wv  [0:7];
  logic [31:0]       win [0:15];
  logic [255:0]      rnd;
  logic [31:0]       w_new;
  logic [31:0]       fill;
  logic              nw_ok;
  logic [12:0]       rd_idx;
  logic [3:0]        cap_k;
  logic [12:0]       cap_idx;
  logic              rd_valid;
  logic              last_blk;

  assign nw_ok    = {1'b0, num_words} <= MAX_LEN;
  assign rd_idx   = {blk, cnt[3:0]};
  assign cap_k    = 4'(cnt - 7'd1);
  assign cap_idx  = {blk, cap_k};
  assign rd_valid = (state == LOAD) && !cnt[4] && (rd_idx < {1'b0, nw});
  assign last_blk = (blk == nb - 9'd1);
  assign w_new    = s1(win[14]) + win[9] + s0(win[1]) + win[0];

  // Each captured slot is message data, the 0x80000000 marker, the bit length, or zero.
  always_comb begin
    fill = '0;
    if (cap_idx < {1'b0, nw})
      fill = memory_read_data;
    else if (cap_idx == {1'b0, nw})
      fill = PAD_WORD;
    else if (last_blk && cap_k == 4'd15)
      fill = {15'd0, nw, 5'd0};
  end

  sha256_round u_round (
    .a  (wv[0]),
    .b  (wv[1]),
    .c  (wv[2]),
    .d  (wv[3]),
    .e  (wv[4]),
    .f  (wv[5]),
    .g  (wv[6]),
    .h  (wv[7]),
    .w  (win[0]),
    .k  (K[cnt[5:0]]),
    .nxt(rnd)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start && nw_ok) state_next = LOAD;
      LOAD:     if (cnt == 7'd16) state_next = COMPRESS;
      COMPRESS: if (cnt == 7'd63) state_next = ADD;
      ADD:      state_next = (blk + 9'd1 < nb) ? LOAD : WRITE;
      WRITE:    if (cnt == 7'd7) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      blk   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= (state == IDLE) && start && !nw_ok;
      if (state == IDLE || state_next != state)
        cnt <= '0;
      else
        cnt <= cnt + 7'd1;
      if (state == IDLE)
        blk <= '0;
      else if (state == ADD)
        blk <= blk + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start && nw_ok) begin
          nw       <= num_words;
          nb       <= 9'(((13'(num_words) + 13'd2) >> 4) + 13'd1);
          in_base  <= input_addr;
          out_base <= hash_addr;
          for (int i = 0; i < 8; i++) hv[i] <= IV[i];
        end
      end
      LOAD: begin
        if (cnt != 7'd0) win[cap_k] <= fill;
        if (cnt == 7'd16)
          for (int i = 0; i < 8; i++) wv[i] <= hv[i];
      end
      COMPRESS: begin
        for (int i = 0; i < 8; i++) wv[i] <= rnd[255-32*i -: 32];
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
      end
      ADD: begin
        for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
      end
      default: ;
    endcase
  end

  assign memory_clk   = clk;
  assign busy         = (state == LOAD) || (state == COMPRESS) || (state == ADD) || (state == WRITE);
  assign done         = (state == DONE);
  assign err          = err_q;
  assign enable_write = (state == WRITE);

  // The bus parks at address 0 whenever neither a read nor a write is in flight.
  always_comb begin
    memory_addr       = '0;
    memory_write_data = '0;
    if (state == WRITE) begin
      memory_addr       = out_base + ADDR_W'(cnt[2:0]);
      memory_write_data = hv[cnt[2:0]];
    end else if (rd_valid) begin
      memory_addr = in_base + ADDR_W'(rd_idx);
    end
  end

endmodule
